// File: rtl/psd_chip_pkg.sv
// Shared definitions for the PSD chip digital core.
// Provides:
//   NUMREGS_DEFAULT - number of configuration registers in the regmap
//   REGADDR_W       - regmap address width, derived from NUMREGS_DEFAULT
//   scan_state_t    - state encoding of the DAC scan sequencer
//   scan_is_last()  - true when the code just written ends the sweep
package psd_chip_pkg;

  localparam int NUMREGS_DEFAULT = 67;
  localparam int REGADDR_W       = $clog2(NUMREGS_DEFAULT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    DWELL  = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

  // The next code is formed 9 bits wide, so a carry out of bit 7 ends the
  // sweep instead of wrapping back to a small code. A zero step would repeat
  // the same code forever, so it also ends the sweep after one write.
  function automatic logic scan_is_last(input logic [7:0] code,
                                        input logic [7:0] step,
                                        input logic [7:0] last);
    logic [8:0] nxt;
    nxt = {1'b0, code} + {1'b0, step};
    return (step == 8'd0) || nxt[8] || (nxt[7:0] > last);
  endfunction

endpackage

// File: rtl/dac_scan_sequencer_dwell_counter.sv
// Loadable down-counter with a zero flag, used to time the hold period
// after each accepted DAC write.
// Ports:
//   clk, reset_n - system clock, async active-low reset
//   load         - load load_val (has priority over dec)
//   load_val     - value loaded on load
//   dec          - decrement by one; saturates at zero
//   zero         - count is zero
module dwell_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dac_scan_sequencer.sv
// Autonomous sweep controller for one 8-bit configuration register.
// Steps the register from scan_first to scan_last (inclusive) by scan_step,
// writing each code through a req/ack handshake into the regmap write port
// and holding it for dwell+1 cycles after each accepted write.
// Ports:
//   clk, reset_n   - system clock, async active-low reset
//   start          - launch pulse, honoured only in IDLE
//   abort          - level; forces IDLE
//   scan_addr/first/last/step, dwell - sweep operands, latched at start
//   wr_req/wr_addr/wr_data, wr_ack   - regmap write handshake
//   busy           - not IDLE
//   step_strobe    - pulse the cycle after each accepted write
//   cur_code       - code most recently accepted by the regmap
//   done           - pulse on normal completion
//   error          - pulse the cycle after a start with an illegal address
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | wr_req high, waiting for wr_ack
// DWELL  | holding the accepted code until the dwell counter reaches zero
// FINISH | done pulse, back to IDLE next cycle
module dac_scan_sequencer
  import psd_chip_pkg::*;
#(
  parameter int NUMREGS = NUMREGS_DEFAULT,
  parameter int DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REGADDR_W-1:0] scan_addr,
  input  logic [7:0]           scan_first,
  input  logic [7:0]           scan_last,
  input  logic [7:0]           scan_step,
  input  logic [DWELL_W-1:0]   dwell,
  output logic                 wr_req,
  output logic [REGADDR_W-1:0] wr_addr,
  output logic [7:0]           wr_data,
  input  logic                 wr_ack,
  output logic                 busy,
  output logic                 step_strobe,
  output logic [7:0]           cur_code,
  output logic                 done,
  output logic                 error
);

  localparam logic [REGADDR_W:0] NUMREGS_C = (REGADDR_W + 1)'(NUMREGS);

  scan_state_t          state, state_nxt;
  logic [REGADDR_W-1:0] addr_q;
  logic [7:0]           code_q;
  logic [7:0]           last_q;
  logic [7:0]           step_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 last_pt_q;
  logic [7:0]           cur_code_q;
  logic                 step_strobe_q;
  logic                 error_q;

  logic addr_ok;
  logic start_ok;
  logic start_bad;
  logic ack_take;
  logic dwell_zero;

  assign addr_ok   = ({1'b0, scan_addr} < NUMREGS_C);
  assign start_ok  = start && !abort && (state == IDLE) &&  addr_ok;
  assign start_bad = start && !abort && (state == IDLE) && !addr_ok;
  // An ack is honoured even in an abort cycle so cur_code tracks the regmap.
  assign ack_take  = (state == WRITE) && wr_ack;

  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ack_take),
    .load_val (dwell_q),
    .dec      (state == DWELL),
    .zero     (dwell_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = WRITE;
      WRITE:   if (wr_ack)   state_nxt = DWELL;
      DWELL:   if (dwell_zero) state_nxt = last_pt_q ? FINISH : WRITE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Outputs decoded from state; wr_req falls with the async reset of state.
  always_comb begin
    wr_req = (state == WRITE);
    busy   = (state != IDLE);
    done   = (state == FINISH);
  end

  // Operand latches and sweep datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q        <= '0;
      code_q        <= '0;
      last_q        <= '0;
      step_q        <= '0;
      dwell_q       <= '0;
      last_pt_q     <= 1'b0;
      cur_code_q    <= '0;
      step_strobe_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      step_strobe_q <= ack_take;
      error_q       <= start_bad;
      if (start_ok) begin
        addr_q  <= scan_addr;
        code_q  <= scan_first;
        last_q  <= scan_last;
        step_q  <= scan_step;
        dwell_q <= dwell;
      end
      if (ack_take) begin
        cur_code_q <= code_q;
        last_pt_q  <= scan_is_last(code_q, step_q, last_q);
        if (!scan_is_last(code_q, step_q, last_q)) code_q <= code_q + step_q;
      end
    end
  end

  assign wr_addr     = addr_q;
  assign wr_data     = code_q;
  assign cur_code    = cur_code_q;
  assign step_strobe = step_strobe_q;
  assign error       = error_q;

endmodule

// File: tb/tb_dac_scan_sequencer.sv
module tb_dac_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  scan_addr = '0;
  logic [7:0]  scan_first = '0;
  logic [7:0]  scan_last = '0;
  logic [7:0]  scan_step = '0;
  logic [15:0] dwell = '0;
  logic        wr_ack = 1'b0;
  logic        wr_req;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        step_strobe;
  logic [7:0]  cur_code;
  logic        done;
  logic        error;

  dac_scan_sequencer #(.NUMREGS(67), .DWELL_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .scan_addr   (scan_addr),
    .scan_first  (scan_first),
    .scan_last   (scan_last),
    .scan_step   (scan_step),
    .dwell       (dwell),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .step_strobe (step_strobe),
    .cur_code    (cur_code),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];

  typedef struct {
    int addr;
    int first;
    int last;
    int step;
    int dwl;
    int ack_dly;
    int abort_after;
    int exp_writes;
    int exp_code;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep written as plain arithmetic: every code from first while it fits
  // in 8 bits and does not exceed last; a zero step gives a single point.
  task automatic build_model(input int first, input int last, input int step);
    int c;
    exp_q.delete();
    c = first;
    forever begin
      exp_q.push_back(c);
      if (step == 0) break;
      c = c + step;
      if (c > last || c > 255) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_cur_code"}, cur_code, 0);
    chk({tag, "_step_strobe"}, step_strobe, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic run_scan(input int addr, input int first, input int last, input int step,
                          input int dwl, input int ack_dly, input int abort_after,
                          output int n_acks, output int final_code);
    int cyc, acks, wait_cnt, last_ack, dones, strobes, budget;
    bit prev_req, ack_prev, fin, aborted;
    build_model(first, last, step);
    budget = exp_q.size() * (dwl + ack_dly + 4) + 20;
    scan_addr  = 7'(addr);
    scan_first = 8'(first);
    scan_last  = 8'(last);
    scan_step  = 8'(step);
    dwell      = 16'(dwl);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Operands are latched; disturbing the inputs must not affect the sweep.
    scan_addr  = 7'($urandom);
    scan_first = 8'($urandom);
    scan_last  = 8'($urandom);
    scan_step  = 8'($urandom);
    dwell      = 16'($urandom_range(0, 9));
    cyc = 1; acks = 0; wait_cnt = 0; last_ack = -100; dones = 0; strobes = 0;
    prev_req = 0; ack_prev = 0; fin = 0; aborted = 0;
    while (!fin && cyc < budget) begin
      chk("step_strobe", step_strobe, ack_prev);
      if (step_strobe) strobes++;
      chk("error_in_scan", error, 0);
      chk("busy_in_scan", busy, 1);
      ack_prev = 0; wr_ack = 1'b0; start = 1'b0; abort = 1'b0;
      if (wr_req) begin
        if (!prev_req && acks > 0) chk("ack_to_req_gap", cyc - last_ack - 1, dwl + 1);
        chk("wr_addr", wr_addr, addr);
        if (acks < exp_q.size()) chk("wr_data", wr_data, exp_q[acks]);
        else chk("extra_write", acks, exp_q.size());
        if (wait_cnt == ack_dly) begin
          wr_ack = 1'b1; ack_prev = 1; acks++; last_ack = cyc; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      prev_req = wr_req;
      if (done) begin
        dones++;
        chk("done_time", cyc, last_ack + dwl + 2);
        fin = 1;
      end
      if (!fin && abort_after > 0 && acks == abort_after && cyc == last_ack + 2) begin
        abort = 1'b1; start = 1'b1; aborted = 1; fin = 1;
      end
      if (cyc == 3 && !fin) start = 1'b1;
      tick();
      cyc++;
    end
    if (!fin) chk("scan_timeout", 0, 1);
    wr_ack = 1'b0; start = 1'b0; abort = 1'b0;
    chk("busy_after", busy, 0);
    chk("step_strobe_after", step_strobe, ack_prev);
    if (step_strobe) strobes++;
    if (aborted) begin
      for (int i = 0; i < dwl + 4; i++) begin
        chk("abort_no_req", wr_req, 0);
        chk("abort_no_done", done, 0);
        tick();
      end
      chk("abort_acks", acks, abort_after);
      chk("abort_cur_code", cur_code, exp_q[abort_after - 1]);
      chk("abort_dones", dones, 0);
    end else begin
      chk("n_acks_vs_model", acks, exp_q.size());
      chk("cur_code_vs_model", cur_code, exp_q[exp_q.size() - 1]);
      tick();
      chk("busy_idle", busy, 0);
    end
    chk("strobe_count", strobes, acks);
    n_acks = acks;
    final_code = cur_code;
  endtask

  initial begin
    int n, code, addr, first, last, step, dwl, ack_dly, ab, r;
    tbl[0] = '{13, 10, 20, 5, 3, 0, -1, 3, 20};
    tbl[1] = '{5, 0, 2, 1, 1, 7, -1, 3, 2};
    tbl[2] = '{20, 250, 255, 4, 0, 0, -1, 2, 254};
    tbl[3] = '{7, 33, 100, 0, 2, 1, -1, 1, 33};
    tbl[4] = '{8, 50, 40, 3, 2, 0, -1, 1, 50};
    tbl[5] = '{66, 0, 255, 1, 0, 0, -1, 256, 255};
    tbl[6] = '{3, 10, 100, 10, 4, 1, 2, 2, 20};

    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Illegal addresses: error pulse one cycle later, stay idle.
    for (int i = 0; i < 2; i++) begin
      scan_addr = (i == 0) ? 7'd67 : 7'd127;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("reject_error", error, 1);
      chk("reject_busy", busy, 0);
      tick();
      chk("reject_error_clear", error, 0);
      chk("reject_busy2", busy, 0);
    end

    foreach (tbl[i]) begin
      run_scan(tbl[i].addr, tbl[i].first, tbl[i].last, tbl[i].step, tbl[i].dwl,
               tbl[i].ack_dly, tbl[i].abort_after, n, code);
      chk("tbl_n_writes", n, tbl[i].exp_writes);
      chk("tbl_final_code", code, tbl[i].exp_code);
      tick();
    end

    // Ack and abort in the same cycle: ack still lands, sweep stops.
    scan_addr = 7'd4; scan_first = 8'd40; scan_last = 8'd60; scan_step = 8'd5; dwell = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ackabort_req", wr_req, 1);
    wr_ack = 1'b1; abort = 1'b1;
    tick();
    wr_ack = 1'b0; abort = 1'b0;
    chk("ackabort_strobe", step_strobe, 1);
    chk("ackabort_cur_code", cur_code, 40);
    chk("ackabort_busy", busy, 0);
    chk("ackabort_req_drop", wr_req, 0);
    tick();
    chk("ackabort_strobe_clear", step_strobe, 0);
    chk("ackabort_no_req", wr_req, 0);

    for (int k = 0; k < 20; k++) begin
      addr  = $urandom_range(0, 66);
      first = $urandom_range(0, 255);
      last  = $urandom_range(0, 255);
      r     = $urandom_range(0, 9);
      step  = (r == 0) ? 0 : ((r < 3) ? $urandom_range(1, 3) : $urandom_range(4, 80));
      dwl   = $urandom_range(0, 3);
      ack_dly = $urandom_range(0, 2);
      build_model(first, last, step);
      ab = (dwl >= 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, exp_q.size()) : -1;
      run_scan(addr, first, last, step, dwl, ack_dly, ab, n, code);
      tick();
    end

    // Reset asserted while a write is pending.
    scan_addr = 7'd9; scan_first = 8'd77; scan_last = 8'd90; scan_step = 8'd1; dwell = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rst_pre_req", wr_req, 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    tick();
    reset_n = 1'b1;
    tick();
    check_all_zero("after_mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
